// File: rtl/euclid_degree_tracker.sv
// Degree bookkeeping for the modified-Euclidean key-equation solver.
// Tracks deg R / deg Q across swap/decrement steps. It flags termination
// when min degree < T, or overflow after MAX_ITER steps.
module euclid_degree_tracker #(
    parameter int DEG_W    = 5,
    parameter int SYM_W    = 13,
    parameter int T        = 8,
    parameter int MAX_ITER = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DEG_W-1:0] deg_r_init,
    input  logic [DEG_W-1:0] deg_q_init,
    input  logic             valid_i,
    input  logic [SYM_W-1:0] lead_q_i,
    output logic [DEG_W-1:0] deg_r_o,
    output logic [DEG_W-1:0] deg_q_o,
    output logic             swap_o,
    output logic             step_o,
    output logic             stop_o,
    output logic             done_o,
    output logic             err_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] iter_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [DEG_W-1:0] T_D   = DEG_W'(T);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_ITER);

    state_t           state;
    logic [DEG_W-1:0] deg_r, deg_q;
    logic [CNT_W-1:0] iter;
    logic             swap_r, step_r, stop_r, done_r, err_r;

    logic             swap_c;
    logic [DEG_W-1:0] r_sw, q_sw, r_nx, q_nx, min_nx, min_init;
    logic [CNT_W-1:0] iter_nx;

    // Next-step degrees: optional swap, then saturating decrement of one side
    always_comb begin
        swap_c   = (deg_r < deg_q);
        r_sw     = swap_c ? deg_q : deg_r;
        q_sw     = swap_c ? deg_r : deg_q;
        r_nx     = r_sw;
        q_nx     = q_sw;
        if (lead_q_i == '0) begin
            if (q_sw != '0) q_nx = q_sw - 1'b1;
        end else begin
            if (r_sw != '0) r_nx = r_sw - 1'b1;
        end
        min_nx   = (r_nx < q_nx) ? r_nx : q_nx;
        min_init = (deg_r_init < deg_q_init) ? deg_r_init : deg_q_init;
        iter_nx  = iter + 1'b1;
    end

    // Control FSM and registered outputs; start overrides any concurrent step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            deg_r  <= '0;
            deg_q  <= '0;
            iter   <= '0;
            swap_r <= 1'b0;
            step_r <= 1'b0;
            stop_r <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else if (start) begin
            deg_r  <= deg_r_init;
            deg_q  <= deg_q_init;
            iter   <= '0;
            err_r  <= 1'b0;
            swap_r <= 1'b0;
            step_r <= 1'b0;
            if (min_init < T_D) begin
                state  <= DONE;
                done_r <= 1'b1;
                stop_r <= 1'b1;
            end else begin
                state  <= RUN;
                done_r <= 1'b0;
                stop_r <= 1'b0;
            end
        end else begin
            step_r <= 1'b0;
            stop_r <= 1'b0;
            if (state == RUN && valid_i) begin
                deg_r  <= r_nx;
                deg_q  <= q_nx;
                iter   <= iter_nx;
                swap_r <= swap_c;
                step_r <= 1'b1;
                if (min_nx < T_D) begin
                    stop_r <= 1'b1;
                    done_r <= 1'b1;
                    state  <= DONE;
                end else if (iter_nx == MAX_C) begin
                    err_r  <= 1'b1;
                    done_r <= 1'b1;
                    state  <= DONE;
                end
            end
        end
    end

    assign deg_r_o = deg_r;
    assign deg_q_o = deg_q;
    assign iter_o  = iter;
    assign swap_o  = swap_r;
    assign step_o  = step_r;
    assign stop_o  = stop_r;
    assign done_o  = done_r;
    assign err_o   = err_r;
    assign busy_o  = (state == RUN);

endmodule

// File: tb/tb_euclid_degree_tracker.sv
// Directed bench for euclid_degree_tracker: table-driven cycles on the default
// instance, plus hand sequences for overflow, abort/reset and T=0 saturation.
module tb_euclid_degree_tracker;

    logic        clk, reset, start, valid_i;
    logic [4:0]  deg_r_init, deg_q_init;
    logic [12:0] lead_q_i;

    // instance A: defaults; B: MAX_ITER=4; C: T=0
    logic [4:0] ra, qa, ia, rb, qb, ib, rc, qc, ic;
    logic swa, sta, spa, dna, era, bsa;
    logic swb, stb, spb, dnb, erb, bsb;
    logic swc, stc, spc, dnc, erc, bsc;

    euclid_degree_tracker dut_a (
        .clk(clk), .reset(reset), .start(start), .deg_r_init(deg_r_init),
        .deg_q_init(deg_q_init), .valid_i(valid_i), .lead_q_i(lead_q_i),
        .deg_r_o(ra), .deg_q_o(qa), .swap_o(swa), .step_o(sta), .stop_o(spa),
        .done_o(dna), .err_o(era), .busy_o(bsa), .iter_o(ia));

    euclid_degree_tracker #(.MAX_ITER(4)) dut_b (
        .clk(clk), .reset(reset), .start(start), .deg_r_init(deg_r_init),
        .deg_q_init(deg_q_init), .valid_i(valid_i), .lead_q_i(lead_q_i),
        .deg_r_o(rb), .deg_q_o(qb), .swap_o(swb), .step_o(stb), .stop_o(spb),
        .done_o(dnb), .err_o(erb), .busy_o(bsb), .iter_o(ib));

    euclid_degree_tracker #(.T(0)) dut_c (
        .clk(clk), .reset(reset), .start(start), .deg_r_init(deg_r_init),
        .deg_q_init(deg_q_init), .valid_i(valid_i), .lead_q_i(lead_q_i),
        .deg_r_o(rc), .deg_q_o(qc), .swap_o(swc), .step_o(stc), .stop_o(spc),
        .done_o(dnc), .err_o(erc), .busy_o(bsc), .iter_o(ic));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        st;
        logic [4:0]  ri, qi;
        logic        vl;
        logic [12:0] ld;
        logic [4:0]  e_r, e_q, e_it;
        logic        e_sw, e_step, e_stop, e_done, e_err, e_busy;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(logic st, int ri, int qi, logic vl, int ld,
                                int er, int eq, logic esw, logic estep, logic estop,
                                logic edone, logic eerr, logic ebusy, int eit);
        vec_t v;
        v.st = st; v.ri = 5'(ri); v.qi = 5'(qi); v.vl = vl; v.ld = 13'(ld);
        v.e_r = 5'(er); v.e_q = 5'(eq); v.e_sw = esw; v.e_step = estep;
        v.e_stop = estop; v.e_done = edone; v.e_err = eerr; v.e_busy = ebusy;
        v.e_it = 5'(eit);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs just after an edge, then sample 1 time unit after the next edge
    task automatic cyc(input logic st, input int ri, input int qi, input logic vl, input int ld);
        start = st; deg_r_init = 5'(ri); deg_q_init = 5'(qi); valid_i = vl; lead_q_i = 13'(ld);
        @(posedge clk); #1;
        start = 1'b0; valid_i = 1'b0;
    endtask

    initial begin
        // test 1: 8 non-swapping Q decrements to stop
        vecs[0] = mk(1, 16, 15, 0, 0, 16, 15, 0, 0, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 8; k++)
            vecs[k] = mk(0, 0, 0, 1, 0, 16, 15 - k, 0, 1, (k == 8), (k == 8), 0, (k != 8), k);
        vecs[9]  = mk(0, 0, 0, 0, 0, 16, 7, 0, 0, 0, 1, 0, 0, 8);
        vecs[10] = mk(0, 0, 0, 1, 0, 16, 7, 0, 0, 0, 1, 0, 0, 8);
        // test 2: swapping step with nonzero lead
        vecs[11] = mk(1, 10, 12, 0, 0, 10, 12, 0, 0, 0, 0, 0, 1, 0);
        vecs[12] = mk(0, 0, 0, 1, 'h1A5, 11, 10, 1, 1, 0, 0, 0, 1, 1);
        vecs[13] = mk(0, 0, 0, 0, 0, 11, 10, 1, 0, 0, 0, 0, 1, 1);
        // test 3: immediate termination on start, valid ignored afterwards
        vecs[14] = mk(1, 16, 5, 0, 0, 16, 5, 0, 0, 1, 1, 0, 0, 0);
        vecs[15] = mk(0, 0, 0, 1, 0, 16, 5, 0, 0, 0, 1, 0, 0, 0);
        vecs[16] = mk(0, 0, 0, 1, 0, 16, 5, 0, 0, 0, 1, 0, 0, 0);

        reset = 1'b0; start = 1'b0; valid_i = 1'b0;
        deg_r_init = '0; deg_q_init = '0; lead_q_i = '0;
        #12;
        chk("rst_deg_r", ra, 0); chk("rst_deg_q", qa, 0); chk("rst_iter", ia, 0);
        chk("rst_flags", {swa, sta, spa, dna, era, bsa}, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++) begin
            cyc(vecs[i].st, vecs[i].ri, vecs[i].qi, vecs[i].vl, vecs[i].ld);
            chk($sformatf("v%0d deg_r", i), ra, vecs[i].e_r);
            chk($sformatf("v%0d deg_q", i), qa, vecs[i].e_q);
            chk($sformatf("v%0d iter", i), ia, vecs[i].e_it);
            chk($sformatf("v%0d swap", i), swa, vecs[i].e_sw);
            chk($sformatf("v%0d step", i), sta, vecs[i].e_step);
            chk($sformatf("v%0d stop", i), spa, vecs[i].e_stop);
            chk($sformatf("v%0d done", i), dna, vecs[i].e_done);
            chk($sformatf("v%0d err", i), era, vecs[i].e_err);
            chk($sformatf("v%0d busy", i), bsa, vecs[i].e_busy);
        end

        // test 4: overflow on instance B (MAX_ITER=4), equal degrees
        cyc(1, 20, 20, 0, 0);
        chk("ovf_busy0", bsb, 1);
        for (int k = 1; k <= 4; k++) begin
            cyc(0, 0, 0, 1, 3);
            chk($sformatf("ovf_stop%0d", k), spb, 0);
            chk($sformatf("ovf_step%0d", k), stb, 1);
        end
        chk("ovf_err", erb, 1); chk("ovf_done", dnb, 1); chk("ovf_iter", ib, 4);
        chk("ovf_busy", bsb, 0); chk("ovf_deg_r", rb, 18); chk("ovf_deg_q", qb, 18);
        chk("ovf_swap", swb, 1);
        cyc(0, 0, 0, 1, 3);
        chk("ovf_hold_iter", ib, 4);
        cyc(1, 20, 20, 0, 0);
        chk("ovf_clr_err", erb, 0); chk("ovf_clr_done", dnb, 0); chk("ovf_clr_iter", ib, 0);

        // test 5: abort by start with simultaneous valid, then async reset mid-run
        cyc(1, 16, 15, 0, 0);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, 0);
        chk("abort_pre_q", qa, 12);
        cyc(1, 12, 11, 1, 0);
        chk("abort_deg_r", ra, 12); chk("abort_deg_q", qa, 11);
        chk("abort_iter", ia, 0); chk("abort_step", sta, 0); chk("abort_busy", bsa, 1);
        cyc(0, 0, 0, 1, 5);
        chk("abort_step2_r", ra, 11); chk("abort_step2_iter", ia, 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_deg", {ra, qa, ia}, 0);
        chk("mid_rst_flags", {swa, sta, spa, dna, era, bsa}, 0);
        @(posedge clk); #1;
        chk("mid_rst_hold_flags", {swa, sta, spa, dna, era, bsa}, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // test 6: T=0 on instance C, decrement saturates at zero
        cyc(1, 1, 0, 0, 0);
        chk("t0_busy", bsc, 1); chk("t0_stop0", spc, 0);
        for (int k = 1; k <= 3; k++) begin
            cyc(0, 0, 0, 1, 0);
            chk($sformatf("t0_q%0d", k), qc, 0);
            chk($sformatf("t0_r%0d", k), rc, 1);
            chk($sformatf("t0_stop%0d", k), spc, 0);
        end
        chk("t0_iter", ic, 3); chk("t0_done", dnc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
